scrambler: RTL and testbench

//  DisplayPort main-link scrambler for two lanes, two symbols/lane/clock; feeds the phy

---
 rtl/scrambler_pkg.sv | 39 +++
 rtl/scr_lane.sv | 79 +++++++
 rtl/scrambler.sv | 51 +++++
 tb/tb_scrambler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared symbols, LFSR constants and the per-byte scrambling step
// for the DisplayPort main-link scrambler.
package scrambler_pkg;

    localparam int          SR_INTERVAL = 512;
    localparam logic [7:0]  SYM_BS      = 8'hBC;
    localparam logic [7:0]  SYM_SR      = 8'h1C;
    localparam logic [15:0] SCR_SEED    = 16'hFFFF;
    localparam logic [15:0] SCR_POLY    = 16'h0039;

    typedef struct packed {
        logic [7:0]  dat;
        logic [15:0] lfsr;
        logic        is_bs;
    } step_t;

    // One byte through the Galois LFSR; K symbols pass through unscrambled
    function automatic step_t scr_step(
        input logic [15:0] lfsr,
        input logic [7:0]  din,
        input logic        isk,
        input logic [15:0] poly
    );
        step_t       r;
        logic [15:0] l;
        logic [7:0]  k;
        l = lfsr;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            k[i] = l[15];
            l    = {l[14:0], 1'b0} ^ (l[15] ? poly : 16'h0000);
        end
        r.dat   = isk ? din : din ^ k;
        r.lfsr  = l;
        r.is_bs = isk && (din == SYM_BS);
        return r;
    endfunction

endpackage

// File: rtl/scr_lane.sv
// One scrambler lane: two chained byte steps per clock, BS counter,
// SR substitution with LFSR reseed, and registered outputs.
module scr_lane
    import scrambler_pkg::*;
#(
    parameter int          SR_INTERVAL = scrambler_pkg::SR_INTERVAL,
    parameter logic [15:0] SEED        = SCR_SEED,
    parameter logic [15:0] POLY        = SCR_POLY
) (
    input  logic        dpclk,
    input  logic        reset,
    input  logic        scren,
    input  logic [15:0] indat,
    input  logic [1:0]  inisk,
    output logic [15:0] scrdat,
    output logic [1:0]  scrisk
);

    localparam int             CW      = $clog2(SR_INTERVAL);
    localparam logic [CW-1:0]  CNT_MAX = CW'(SR_INTERVAL - 1);

    logic [15:0]   lfsr;
    logic [CW-1:0] cnt;

    step_t         s0;
    step_t         s1;
    logic [7:0]    o0;
    logic [7:0]    o1;
    logic [15:0]   l1;
    logic [15:0]   lfsr_nxt;
    logic [CW-1:0] c1;
    logic [CW-1:0] cnt_nxt;

    // Low byte first; an SR in the low byte reseeds before the high byte
    always_comb begin
        s0       = scr_step(lfsr, indat[7:0], inisk[0], POLY);
        o0       = s0.dat;
        l1       = s0.lfsr;
        c1       = cnt;
        if (s0.is_bs) begin
            if (cnt == '0) begin
                o0 = SYM_SR;
                l1 = SEED;
            end
            c1 = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        end
        s1       = scr_step(l1, indat[15:8], inisk[1], POLY);
        o1       = s1.dat;
        lfsr_nxt = s1.lfsr;
        cnt_nxt  = c1;
        if (s1.is_bs) begin
            if (c1 == '0) begin
                o1       = SYM_SR;
                lfsr_nxt = SEED;
            end
            cnt_nxt = (c1 == CNT_MAX) ? '0 : c1 + CW'(1);
        end
    end

    always_ff @(posedge dpclk or posedge reset) begin
        if (reset) begin
            scrdat <= '0;
            scrisk <= '0;
            lfsr   <= SEED;
            cnt    <= '0;
        end else if (scren) begin
            scrdat <= {o1, o0};
            scrisk <= inisk;
            lfsr   <= lfsr_nxt;
            cnt    <= cnt_nxt;
        end else begin
            scrdat <= indat;
            scrisk <= inisk;
            lfsr   <= SEED;
            cnt    <= '0;
        end
    end

endmodule

// File: rtl/scrambler.sv
// Two-lane DisplayPort main-link scrambler feeding the phy output mux.
// Each lane keeps its own LFSR and BS counter.
module scrambler
    import scrambler_pkg::*;
#(
    parameter int          SR_INTERVAL = scrambler_pkg::SR_INTERVAL,
    parameter logic [15:0] SEED        = SCR_SEED,
    parameter logic [15:0] POLY        = SCR_POLY
) (
    input  logic        dpclk,
    input  logic        reset,
    input  logic        scren,
    input  logic [15:0] indat0,
    input  logic [1:0]  inisk0,
    input  logic [15:0] indat1,
    input  logic [1:0]  inisk1,
    output logic [15:0] scrdat0,
    output logic [1:0]  scrisk0,
    output logic [15:0] scrdat1,
    output logic [1:0]  scrisk1
);

    scr_lane #(
        .SR_INTERVAL (SR_INTERVAL),
        .SEED        (SEED),
        .POLY        (POLY)
    ) u_lane0 (
        .dpclk  (dpclk),
        .reset  (reset),
        .scren  (scren),
        .indat  (indat0),
        .inisk  (inisk0),
        .scrdat (scrdat0),
        .scrisk (scrisk0)
    );

    scr_lane #(
        .SR_INTERVAL (SR_INTERVAL),
        .SEED        (SEED),
        .POLY        (POLY)
    ) u_lane1 (
        .dpclk  (dpclk),
        .reset  (reset),
        .scren  (scren),
        .indat  (indat1),
        .inisk  (inisk1),
        .scrdat (scrdat1),
        .scrisk (scrisk1)
    );

endmodule

// File: tb/tb_scrambler.sv
// Scoreboard bench for the two-lane scrambler; the reference model indexes
// a precomputed keystream by byte position since the last reseed.
module tb_scrambler;

    logic        dpclk = 1'b0;
    logic        reset;
    logic        scren;
    logic [15:0] indat0, indat1;
    logic [1:0]  inisk0, inisk1;
    logic [15:0] scrdat0, scrdat1;
    logic [1:0]  scrisk0, scrisk1;

    scrambler dut (
        .dpclk   (dpclk),
        .reset   (reset),
        .scren   (scren),
        .indat0  (indat0),
        .inisk0  (inisk0),
        .indat1  (indat1),
        .inisk1  (inisk1),
        .scrdat0 (scrdat0),
        .scrisk0 (scrisk0),
        .scrdat1 (scrdat1),
        .scrisk1 (scrisk1)
    );

    always #5 dpclk = ~dpclk;

    typedef struct {
        logic [15:0] d0;
        logic [1:0]  k0;
        logic [15:0] d1;
        logic [1:0]  k1;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // keystream bit j = LFSR msb after j steps from the seed
    bit ksb[262144];
    int m_pos[2];
    int m_cnt[2];

    function automatic logic [7:0] ks_byte(input int p);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ksb[8*p+i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [17:0] act,
                       input logic [17:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_lane(input int ln, input bit sc, input logic [15:0] d,
                              input logic [1:0] k, output logic [15:0] o);
        logic [7:0] x;
        o = d;
        if (!sc) begin
            m_pos[ln] = 0;
            m_cnt[ln] = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                x = d[8*b +: 8];
                if (k[b] && x == 8'hBC) begin
                    if (m_cnt[ln] == 0) begin
                        o[8*b +: 8] = 8'h1C;
                        m_pos[ln]   = 0;
                    end else begin
                        m_pos[ln]++;
                    end
                    m_cnt[ln] = (m_cnt[ln] + 1) % 512;
                end else if (k[b]) begin
                    m_pos[ln]++;
                end else begin
                    o[8*b +: 8] = x ^ ks_byte(m_pos[ln]);
                    m_pos[ln]++;
                end
            end
        end
    endtask

    // Entered at a negedge; drives one word, queues its expectation
    task automatic send(input bit sc, input logic [15:0] d0, input logic [1:0] k0,
                        input logic [15:0] d1, input logic [1:0] k1,
                        input int fix = -1, input logic [15:0] fd = 16'h0,
                        input logic [1:0] fk = 2'b00);
        exp_t e;
        scren  = sc;
        indat0 = d0;
        inisk0 = k0;
        indat1 = d1;
        inisk1 = k1;
        model_lane(0, sc, d0, k0, e.d0);
        model_lane(1, sc, d1, k1, e.d1);
        e.k0 = k0;
        e.k1 = k1;
        if (fix == 0) begin e.d0 = fd; e.k0 = fk; end
        if (fix == 1) begin e.d1 = fd; e.k1 = fk; end
        q.push_back(e);
        @(negedge dpclk);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_l0"}, {scrdat0, scrisk0}, 18'h0);
        chk({tag, "_l1"}, {scrdat1, scrisk1}, 18'h0);
        m_pos[0] = 0; m_cnt[0] = 0;
        m_pos[1] = 0; m_cnt[1] = 0;
        @(negedge dpclk);
        @(negedge dpclk);
        reset = 1'b0;
    endtask

    task automatic rnd_byte(output logic [7:0] b, output logic k);
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) begin
            b = 8'hBC; k = 1'b1;
        end else if (r < 5) begin
            b = 8'($urandom); k = 1'b1;
        end else begin
            b = 8'($urandom); k = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge dpclk);
            #1;
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                chk("lane0", {scrdat0, scrisk0}, {e.d0, e.k0});
                chk("lane1", {scrdat1, scrisk1}, {e.d1, e.k1});
            end
        end
    end

    initial begin
        logic [15:0] l;
        logic [15:0] d0, d1;
        logic [1:0]  k0, k1;
        bit          sc;
        l = 16'hFFFF;
        for (int j = 0; j < 262144; j++) begin
            ksb[j] = l[15];
            l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
        end
        m_pos[0] = 0; m_cnt[0] = 0;
        m_pos[1] = 0; m_cnt[1] = 0;

        reset  = 1'b1;
        scren  = 1'b1;
        indat0 = 16'h0; inisk0 = 2'b00;
        indat1 = 16'h0; inisk1 = 2'b00;
        #1;
        chk("rst0", {scrdat0, scrisk0}, 18'h0);
        chk("rst1", {scrdat1, scrisk1}, 18'h0);
        @(negedge dpclk);
        @(negedge dpclk);
        reset = 1'b0;

        send(1, 16'h0000, 2'b00, 16'h0000, 2'b00, 0, 16'h17FF, 2'b00);
        send(1, 16'h0000, 2'b00, 16'h0000, 2'b00, 0, 16'h14C0, 2'b00);

        do_reset("rst_t2");
        send(1, 16'h00BC, 2'b01, 16'h0000, 2'b00, 0, 16'hFF1C, 2'b01);
        repeat (511) send(1, 16'h00BC, 2'b01, 16'h0000, 2'b00);
        send(1, 16'h00BC, 2'b01, 16'hBCBC, 2'b11);
        send(1, 16'hBCBC, 2'b11, 16'h0000, 2'b00);

        do_reset("rst_t4");
        send(1, 16'h7C00, 2'b10, 16'h0000, 2'b00, 0, 16'h7CFF, 2'b10);

        send(0, 16'h1234, 2'b00, 16'hA55A, 2'b11, 1, 16'hA55A, 2'b11);
        send(1, 16'h0000, 2'b00, 16'h0000, 2'b00, 1, 16'h17FF, 2'b00);

        repeat (5) send(1, 16'($urandom), 2'b00, 16'($urandom), 2'b00);
        do_reset("rst_mid");
        send(1, 16'h0000, 2'b00, 16'h0000, 2'b00, 0, 16'h17FF, 2'b00);

        sc = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) sc = ~sc;
            if ($urandom_range(0, 1499) == 0) do_reset("rst_rnd");
            rnd_byte(d0[7:0], k0[0]);
            rnd_byte(d0[15:8], k0[1]);
            rnd_byte(d1[7:0], k1[0]);
            rnd_byte(d1[15:8], k1[1]);
            send(sc, d0, k0, d1, k1);
        end

        @(posedge dpclk);
        #2;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d expected 0 pending", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
